multdiv_sequencer: RTL and testbench

//   Control FSM for the multi-cycle multiply/divide unit. Accepts one-cycle

---
 rtl/multdiv_sequencer_if.sv | 42 ++++
 rtl/multdiv_sequencer.sv | 113 +++++++++++
 tb/tb_multdiv_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Handshake and datapath-control bundle between the pipeline and the
// multiply/divide sequencer; master = pipeline side, slave = sequencer.
interface multdiv_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             divisor_zero;
    logic             dp_load;
    logic             dp_step;
    logic             dp_is_div;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             data_resultRDY;
    logic             data_exception;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output divisor_zero,
        input  dp_load,
        input  dp_step,
        input  dp_is_div,
        input  busy,
        input  count,
        input  data_resultRDY,
        input  data_exception
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  divisor_zero,
        output dp_load,
        output dp_step,
        output dp_is_div,
        output busy,
        output count,
        output data_resultRDY,
        output data_exception
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control FSM for the multi-cycle multiply/divide datapath: LOAD, N steps, DONE.
// Optional MULTDIV_DIV0_FAST_EN: divide-by-zero skips the step cycles entirely.
module multdiv_sequencer #(
    parameter int CNT_W       = 6,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                clock,
    input  logic                clr,
    multdiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             is_div;
    logic             div0;

    logic             start;
    logic             start_div;
    logic [CNT_W-1:0] last;
    logic             step_last;
    logic             fast_div0;

    // Start decode: multiply wins when both pulses arrive together.
    always_comb begin
        start     = bus.ctrl_MULT | bus.ctrl_DIV;
        start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
        last      = is_div ? DIV_LAST : MULT_LAST;
        step_last = (count == last);
`ifdef MULTDIV_DIV0_FAST_EN
        fast_div0 = is_div & bus.divisor_zero;
`else
        fast_div0 = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; starts seen in LOAD or RUN are dropped.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                state_next = fast_div0 ? DONE : RUN;
            end
            RUN: begin
                if (step_last) state_next = DONE;
            end
            DONE: begin
                state_next = start ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Step counter, op select and divide-by-zero latch.
    always_ff @(posedge clock) begin
        if (clr) begin
            count  <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) is_div <= start_div;
                end
                LOAD: begin
                    count <= '0;
                    div0  <= bus.divisor_zero & is_div;
                end
                RUN: begin
                    count <= step_last ? '0 : count + 1'b1;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from the registered state.
    always_comb begin
        bus.dp_load        = (state == LOAD);
        bus.dp_step        = (state == RUN);
        bus.busy           = (state == LOAD) | (state == RUN);
        bus.data_resultRDY = (state == DONE);
        bus.data_exception = (state == DONE) & div0;
        bus.dp_is_div      = is_div;
        bus.count          = count;
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: vector table of single ops plus
// hand-written reset, ignored-start, back-to-back and abort sequences.
module tb_multdiv_sequencer;

    logic clock = 1'b0;
    logic clr;

    always #5 clock = ~clock;

    multdiv_sequencer_if #(.CNT_W(6)) bus ();

    multdiv_sequencer #(
        .CNT_W      (6),
        .MULT_CYCLES(32),
        .DIV_CYCLES (32)
    ) dut (
        .clock(clock),
        .clr  (clr),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  m;
        logic  d;
        logic  z;
        int    lat;
        int    steps;
        logic  exc;
        logic  is_div;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, bus.dp_load, bus.dp_step, bus.dp_is_div, bus.busy,
                bus.data_resultRDY, bus.data_exception, bus.count};
    endfunction

    // Pulse is driven during cycle t; offset c observed after edge t+c.
    task automatic run_op(input vec_t v);
        int   rdy_at = -1;
        int   rdy_n = 0;
        int   steps = 0;
        int   loads = 0;
        int   load_at = -1;
        logic seq_ok = 1'b1;
        logic exc = 1'b0;
        logic isd = 1'b0;
        bus.ctrl_MULT    = v.m;
        bus.ctrl_DIV     = v.d;
        bus.divisor_zero = v.z;
        for (int c = 1; c <= 60; c++) begin
            tick();
            bus.ctrl_MULT = 1'b0;
            bus.ctrl_DIV  = 1'b0;
            if (bus.dp_load) begin
                loads++;
                load_at = c;
            end
            if (bus.dp_step) begin
                if (bus.count !== 6'(steps)) seq_ok = 1'b0;
                steps++;
            end
            if (bus.busy !== (bus.dp_load | bus.dp_step)) seq_ok = 1'b0;
            if (bus.data_resultRDY) begin
                rdy_n++;
                if (rdy_at < 0) begin
                    rdy_at = c;
                    exc    = bus.data_exception;
                    isd    = bus.dp_is_div;
                end
            end
        end
        check({v.name, "_load_at"}, load_at, 1);
        check({v.name, "_loads"}, loads, 1);
        check({v.name, "_steps"}, steps, v.steps);
        check({v.name, "_rdy_at"}, rdy_at, v.lat);
        check({v.name, "_rdy_n"}, rdy_n, 1);
        check({v.name, "_exc"}, 32'(exc), 32'(v.exc));
        check({v.name, "_is_div"}, 32'(isd), 32'(v.is_div));
        check({v.name, "_seq"}, 32'(seq_ok), 32'd1);
        check({v.name, "_is_div_hold"}, 32'(bus.dp_is_div), 32'(v.is_div));
        bus.divisor_zero = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int dz_lat;
        int dz_steps;
        int rdy1;
        int rdy2;
        int pulse2;
        int inj;
        int rdy_n;
        int load_after;
        int found;

`ifdef MULTDIV_DIV0_FAST_EN
        dz_lat   = 2;
        dz_steps = 0;
`else
        dz_lat   = 34;
        dz_steps = 32;
`endif
        vecs[0] = '{"mul",      1'b1, 1'b0, 1'b0, 34, 32, 1'b0, 1'b0};
        vecs[1] = '{"div",      1'b0, 1'b1, 1'b0, 34, 32, 1'b0, 1'b1};
        vecs[2] = '{"div_zero", 1'b0, 1'b1, 1'b1, dz_lat, dz_steps, 1'b1, 1'b1};
        vecs[3] = '{"both",     1'b1, 1'b1, 1'b0, 34, 32, 1'b0, 1'b0};
        vecs[4] = '{"mul_z",    1'b1, 1'b0, 1'b1, 34, 32, 1'b0, 1'b0};

        // reset with random controls
        clr              = 1'b1;
        bus.ctrl_MULT    = 1'($urandom);
        bus.ctrl_DIV     = 1'($urandom);
        bus.divisor_zero = 1'($urandom);
        tick();
        check("rst_cyc1", outs(), 32'd0);
        bus.ctrl_MULT    = 1'($urandom);
        bus.ctrl_DIV     = 1'($urandom);
        tick();
        check("rst_cyc2", outs(), 32'd0);
        clr              = 1'b0;
        bus.ctrl_MULT    = 1'b0;
        bus.ctrl_DIV     = 1'b0;
        bus.divisor_zero = 1'b0;
        tick();
        tick();
        check("idle_after_rst", outs(), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i]);
        end

        // ignored divide during RUN, then back-to-back divide from DONE
        rdy1       = -1;
        rdy2       = -1;
        pulse2     = -1;
        inj        = 0;
        rdy_n      = 0;
        load_after = 0;
        bus.ctrl_DIV = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            bus.ctrl_DIV = 1'b0;
            if (pulse2 >= 0 && c == pulse2 + 1) load_after = int'(bus.dp_load);
            if (bus.dp_step && bus.count == 6'd5 && inj == 0) begin
                bus.ctrl_DIV = 1'b1;
                inj = 1;
            end
            if (bus.data_resultRDY) begin
                rdy_n++;
                if (rdy1 < 0) begin
                    rdy1 = c;
                    bus.ctrl_DIV = 1'b1;
                    pulse2 = c;
                end else if (rdy2 < 0) begin
                    rdy2 = c;
                end
            end
        end
        check("ign_injected", inj, 1);
        check("ign_rdy1_at", rdy1, 34);
        check("b2b_load", load_after, 1);
        check("b2b_rdy2_delta", rdy2 - pulse2, 34);
        check("b2b_rdy_n", rdy_n, 2);

        // clr in the middle of RUN aborts the op
        bus.ctrl_MULT = 1'b1;
        found = 0;
        for (int c = 1; c <= 40 && found == 0; c++) begin
            tick();
            bus.ctrl_MULT = 1'b0;
            if (bus.dp_step && bus.count == 6'd10) found = 1;
        end
        check("abort_reach_cnt10", found, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_outs", outs(), 32'd0);
        rdy_n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.data_resultRDY || bus.busy) rdy_n++;
        end
        check("abort_no_rdy", rdy_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
